// File: rtl/chrom_eval_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : chrom_eval_sequencer
// Purpose  : Avalon-MM slave that runs one chromosome evaluation at a time on
//            the serial evaluation datapath. Software loads a chromosome word,
//            issues start. The block pulses chrom_start, holds chrom_data
//            stable and waits for a rising edge on the (asynchronous) done
//            level. It then counts the completion and raises a level irq.
// Ports    : clk, reset_n (async, active-low)
//            address/write/writedata/readdata - Avalon slave, 1-cycle read
//            irq          - level interrupt (irq_en & (done | timeout))
//            chrom_data   - chromosome word to datapath
//            chrom_start  - one-cycle start pulse to datapath
//            done_in      - datapath done level, asynchronous to clk
// Options  : SEQ_TIMEOUT_EN - adds a watchdog that abandons a run after
//            TIMEOUT_CYCLES cycles in WAIT_DONE and sets timeout_flag.
// Revision : 1.0 - initial release
// ============================================================================
module chrom_eval_sequencer #(
  parameter int CHROM_W = 32,
  parameter int COUNT_W = 16
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         address,
  input  logic               write,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               irq,
  output logic [CHROM_W-1:0] chrom_data,
  output logic               chrom_start,
  input  logic               done_in
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 done_meta_q, done_sync_q, done_prev_q;
  logic                 irq_en_q;
  logic                 done_flag_q, done_flag_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [CHROM_W-1:0]   chrom_q;
  logic [31:0]          readdata_q, readdata_d;
  logic                 irq_q;

  logic done_edge, busy, complete, timeout_hit, wdog_expired, timeout_flag;
  logic ctrl_wr, status_wr, chrom_wr, count_wr, start_cmd, abort_cmd;

  assign ctrl_wr   = write && (address == 2'd0);
  assign status_wr = write && (address == 2'd1);
  assign chrom_wr  = write && (address == 2'd2);
  assign count_wr  = write && (address == 2'd3);
  // Abort dominates start when both bits are set in one CTRL write.
  assign start_cmd = ctrl_wr && writedata[0] && !writedata[1];
  assign abort_cmd = ctrl_wr && writedata[1];

  // Only a fresh rising edge completes a run; a level left high from an
  // earlier run is invisible.
  assign done_edge = done_sync_q && !done_prev_q;

  // --------------------------------------------------------------------------
  // FSM next-state / outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    chrom_start = 1'b0;
    busy        = 1'b1;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start_cmd) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        chrom_start = 1'b1;
        state_d     = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // Priority: abort, then completion, then watchdog.
        if (abort_cmd) begin
          state_d = ST_IDLE;
        end else if (done_edge) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else if (wdog_expired) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flag / counter next state: set beats a same-cycle W1C clear.
  always_comb begin
    done_flag_d = done_flag_q;
    if (status_wr && writedata[1]) done_flag_d = 1'b0;
    if (complete)                  done_flag_d = 1'b1;

    count_d = count_wr ? '0 : count_q;
    if (complete && (count_d != '1)) count_d = count_d + COUNT_W'(1);
  end

  always_comb begin
    readdata_d = 32'd0;
    case (address)
      2'd0:    readdata_d = {29'd0, irq_en_q, 2'b00};
      2'd1:    readdata_d = {29'd0, timeout_flag, done_flag_q, busy};
      2'd2:    readdata_d = 32'(chrom_q);
      default: readdata_d = 32'(count_q);
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      done_meta_q <= 1'b0;
      done_sync_q <= 1'b0;
      done_prev_q <= 1'b0;
      irq_en_q    <= 1'b0;
      done_flag_q <= 1'b0;
      count_q     <= '0;
      chrom_q     <= '0;
      readdata_q  <= 32'd0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_meta_q <= done_in;
      done_sync_q <= done_meta_q;
      done_prev_q <= done_sync_q;
      if (ctrl_wr) irq_en_q <= writedata[2];
      done_flag_q <= done_flag_d;
      count_q     <= count_d;
      // The datapath sees chrom_q directly, so it is frozen during a run.
      if (chrom_wr && !busy) chrom_q <= writedata[CHROM_W-1:0];
      readdata_q  <= readdata_d;
      irq_q       <= irq_en_q && (done_flag_q || timeout_flag);
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] wdog_q;
  logic        timeout_flag_q;

  // Watchdog is zeroed while in LAUNCH so it starts at 0 on WAIT_DONE entry.
  assign wdog_expired = (wdog_q == 32'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = timeout_flag_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q         <= 32'd0;
      timeout_flag_q <= 1'b0;
    end else begin
      if (state_q == ST_LAUNCH)         wdog_q <= 32'd0;
      else if (state_q == ST_WAIT_DONE) wdog_q <= wdog_q + 32'd1;
      if (timeout_hit)                      timeout_flag_q <= 1'b1;
      else if (status_wr && writedata[2])   timeout_flag_q <= 1'b0;
    end
  end
`else
  assign wdog_expired = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  assign readdata   = readdata_q;
  assign irq        = irq_q;
  assign chrom_data = chrom_q;

endmodule
`default_nettype wire

// File: tb/tb_chrom_eval_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_chrom_eval_sequencer
// Purpose  : Self-checking bench for chrom_eval_sequencer. Randomized register
//            traffic and done_in activity are checked against a register-level
//            model (flags, count, chromosome, irq_en, start-pulse tally).
//            Build with +define+SEQ_TIMEOUT_EN to exercise the watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chrom_eval_sequencer;

  localparam int          CHROM_W = 32;
  localparam int          COUNT_W = 2;
  localparam int          TMO     = 50;
  localparam logic [31:0] CNT_MAX = (32'd1 << COUNT_W) - 32'd1;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [1:0]         address = 2'd0;
  logic               write = 1'b0;
  logic [31:0]        writedata = 32'd0;
  logic [31:0]        readdata;
  logic               irq;
  logic [CHROM_W-1:0] chrom_data;
  logic               chrom_start;
  logic               done_in = 1'b0;

  chrom_eval_sequencer #(
    .CHROM_W(CHROM_W),
    .COUNT_W(COUNT_W)
`ifdef SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .chrom_data (chrom_data),
    .chrom_start(chrom_start),
    .done_in    (done_in)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic        m_irq_en = 1'b0;
  logic        m_done   = 1'b0;
  logic        m_tmo    = 1'b0;
  logic [31:0] m_count  = 32'd0;
  logic [31:0] m_chrom  = 32'd0;
  int          m_pulses = 0;

  int pulses = 0;
  int checks = 0;
  int errors = 0;

  always @(negedge clk) if (chrom_start) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  function automatic logic [31:0] exp_status(input logic busy);
    return {29'd0, m_tmo, m_done, busy};
  endfunction

  function automatic logic exp_irq();
    return m_irq_en & (m_done | m_tmo);
  endfunction

  task automatic model_reset();
    m_irq_en = 1'b0; m_done = 1'b0; m_tmo = 1'b0;
    m_count = 32'd0; m_chrom = 32'd0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] r;
    rd(2'd0, r); check({tag, "_ctrl"},   r, {29'd0, m_irq_en, 2'b00});
    rd(2'd1, r); check({tag, "_status"}, r, exp_status(1'b0));
    rd(2'd2, r); check({tag, "_chrom"},  r, m_chrom);
    rd(2'd3, r); check({tag, "_count"},  r, m_count);
    check({tag, "_irq"},    32'(irq), 32'(exp_irq()));
    check({tag, "_cdata"},  chrom_data, m_chrom);
    check({tag, "_pulses"}, 32'(pulses), 32'(m_pulses));
  endtask

  task automatic launch(input logic [31:0] c, input logic ie);
    wr(2'd2, c);
    m_chrom = c;
    wr(2'd0, {29'd0, ie, 2'b01});
    m_irq_en = ie;
    m_pulses++;
    check("launch_pulse", 32'(chrom_start), 32'd1);
  endtask

  // Full run ending in a done_in rising edge; checks the 3-edge latency.
  task automatic do_run(input logic [31:0] c, input logic ie, input int dly,
                        input bit dbl_start, input bit busy_chrom_wr);
    launch(c, ie);
    address = 2'd1;
    @(negedge clk);
    check("launch_once", 32'(chrom_start), 32'd0);
    cycles(dly);
    if (dbl_start)     wr(2'd0, {29'd0, ie, 2'b01});
    if (busy_chrom_wr) wr(2'd2, $urandom);
    address = 2'd1;
    done_in = 1'b1;
    cycles(3);
    check("done_lat_busy", readdata, exp_status(1'b1));
    m_done = 1'b1;
    if (m_count < CNT_MAX) m_count++;
    @(negedge clk);
    check("done_lat_flag", readdata, exp_status(1'b0));
    check("done_irq", 32'(irq), 32'(ie));
    check("run_cdata", chrom_data, m_chrom);
    check("run_pulses", 32'(pulses), 32'(m_pulses));
    cycles($urandom_range(0, 4));
    done_in = 1'b0;
    cycles(3);
  endtask

  task automatic do_w1c(input logic [31:0] v);
    wr(2'd1, v);
    if (v[1]) m_done = 1'b0;
    if (v[2]) m_tmo  = 1'b0;
    @(negedge clk);
    check("w1c_irq", 32'(irq), 32'(exp_irq()));
  endtask

  task automatic do_abort();
    logic ie2;
    launch($urandom, 1'($urandom_range(0, 1)));
    cycles($urandom_range(1, 6));
    if ($urandom_range(0, 1) == 1) wr(2'd2, 32'hFFFF_FFFF);
    ie2 = 1'($urandom_range(0, 1));
    wr(2'd0, {29'd0, ie2, 1'b1, 1'($urandom_range(0, 1))});
    m_irq_en = ie2;
    done_in = 1'b1; cycles(4); done_in = 1'b0; cycles(3);
    check_all("abort");
  endtask

  task automatic do_idle_noise();
    logic [31:0] c;
    logic        ie;
    c = $urandom; wr(2'd2, c); m_chrom = c;
    ie = 1'($urandom_range(0, 1));
    wr(2'd0, {29'd0, ie, 2'b11});          // start+abort: nothing launched
    m_irq_en = ie;
    ie = 1'($urandom_range(0, 1));
    wr(2'd0, {29'd0, ie, 2'b10});          // abort in IDLE
    m_irq_en = ie;
    done_in = 1'b1; cycles(4); done_in = 1'b0; cycles(3);
    check_all("idle");
  endtask

  initial begin
    logic [31:0] r;

    // Reset
    cycles(3);
    check("rst_cstart", 32'(chrom_start), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", readdata, 32'd0);
    reset_n = 1'b1;
    check_all("reset");

    // Basic run with fixed chromosome, irq enabled, done 10 cycles later
    do_run(32'hA5A5_1234, 1'b1, 10, 1'b0, 1'b0);
    check_all("basic");
    do_w1c(32'h2);

    // done_in already high before start never completes the new run
    done_in = 1'b1; cycles(4);
    launch($urandom, 1'b1);
    address = 2'd1;
    cycles(10);
    check("held_busy", readdata, exp_status(1'b1));
    done_in = 1'b0; cycles(4);
    check("held_busy2", readdata, exp_status(1'b1));
    done_in = 1'b1; cycles(3);
    check("held_lat_busy", readdata, exp_status(1'b1));
    m_done = 1'b1;
    if (m_count < CNT_MAX) m_count++;
    @(negedge clk);
    check("held_flag", readdata, exp_status(1'b0));
    done_in = 1'b0; cycles(3);
    check_all("held");

    // Saturation then clear
    wr(2'd3, 32'd0); m_count = 32'd0;
    for (int i = 0; i < 4; i++) do_run($urandom, 1'b0, $urandom_range(0, 5), 1'b0, 1'b0);
    check_all("sat");
    wr(2'd3, $urandom); m_count = 32'd0;
    check_all("cnt_clr");

`ifdef SEQ_TIMEOUT_EN
    do_w1c(32'h6);
    launch($urandom, 1'b1);
    address = 2'd1;
    cycles(TMO + 1);
    check("tmo_busy", readdata, exp_status(1'b1));
    m_tmo = 1'b1;
    @(negedge clk);
    check("tmo_flag", readdata, exp_status(1'b0));
    check("tmo_irq", 32'(irq), 32'd1);
    check_all("tmo");
    do_w1c(32'h4);
`else
    launch($urandom, 1'b1);
    address = 2'd1;
    cycles(TMO + 10);
    check("wait_forever", readdata, exp_status(1'b1));
    wr(2'd0, {29'd0, 1'b1, 2'b10});
    check_all("no_tmo");
`endif

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0, 1: do_run($urandom, 1'($urandom_range(0, 1)), $urandom_range(1, 8),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        2:    do_abort();
        3:    do_idle_noise();
        default: begin
          if ($urandom_range(0, 1) == 1) begin
            wr(2'd3, $urandom); m_count = 32'd0;
          end
          do_w1c($urandom);
        end
      endcase
      if (i % 5 == 4) check_all("rand");
    end

    // Reset asserted mid-run, while chrom_start is high
    launch($urandom, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_cstart", 32'(chrom_start), 32'd0);
    check("mid_rst_rdata", readdata, 32'd0);
    check("mid_rst_cdata", chrom_data, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cycles(2);
    check_all("mid_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chrom_eval_sequencer.md
Name: chrom_eval_sequencer

Overview:
- Avalon-MM slave controller that sequences one chromosome evaluation at a time on the serial genetic-circuit evaluation datapath.
- Nios software writes a chromosome word and a start command. The block pulses the datapath start and holds the chromosome stable.
- It then waits for the datapath's done level, counts completions and raises an interrupt.
- It replaces software polling of the raw done PIO.

Parameters:
CHROM_W, 32, width of chromosome word presented to datapath (1..32)
COUNT_W, 16, width of completed-evaluation counter (1..32)
TIMEOUT_CYCLES, 1000000, watchdog limit in clk cycles (used only with TIMEOUT_EN)

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
address  input  2  Avalon register select
write  input  1  Avalon write strobe
writedata  input  32  Avalon write data
readdata  output  32  Avalon read data, registered
irq  output  1  level interrupt to Nios
chrom_data  output  CHROM_W  chromosome word to datapath
chrom_start  output  1  one-cycle start pulse to datapath
done_in  input  1  datapath done level, asynchronous to clk

Behaviour:
- Reset values: readdata=0, irq=0, chrom_data=0, chrom_start=0; state IDLE; all flags, irq_en and count cleared.
- Register map:
  - addr0 CTRL: write bit0=start, bit1=abort, bit2=irq_en (stored). Read returns {29'b0, irq_en, 2'b0}.
  - addr1 STATUS: read bit0=busy, bit1=done_flag, bit2=timeout_flag. Writing 1 to bit1 or bit2 clears that flag (W1C).
  - addr2 CHROM: R/W, CHROM_W LSBs, zero-extended on read. Writes while busy are ignored.
  - addr3 COUNT: read returns count, zero-extended. Any write clears count.
- readdata: registered every clk from address, one-cycle read latency, no read strobe required, no read side effects.
- done_in path: two-flop synchronizer, then done_prev register. done_edge = sync & ~done_prev. Only rising edges count; a level held high from a prior run never completes a new run.
- FSM:
  - IDLE: on CTRL write with start=1 and abort=0 -> LAUNCH. busy=0.
  - LAUNCH: chrom_start=1 for exactly this cycle -> WAIT_DONE. busy=1.
  - WAIT_DONE: on done_edge -> IDLE, set done_flag, increment count. On abort write -> IDLE, no flag set, count unchanged. busy=1.
- Latency:
  - chrom_start is high in the cycle after the start write.
  - done_flag is visible on the 3rd rising clk edge after done_in rises, provided setup is met.
- chrom_data holds its register value at all times and never changes while busy.
- Start while busy: ignored.
- Abort in IDLE: no effect.
- Start and abort in the same write: abort wins, nothing launched.
- done_edge and abort write in the same cycle: abort wins, no flag, no count.
- done_edge during IDLE or LAUNCH: ignored.
- W1C clear and flag set in the same cycle: set wins.
- count saturates at 2^COUNT_W-1; it does not wrap.
- irq = irq_en & (done_flag | timeout_flag), registered, so it asserts one cycle after the flag.
- reset_n asserted mid-run: immediate return to IDLE and reset values. chrom_start is never left high.

Optional Feature:
- Macro SEQ_TIMEOUT_EN.
- Defined:
  - 32-bit watchdog cleared on entry to WAIT_DONE and incremented each WAIT_DONE cycle.
  - When it reaches TIMEOUT_CYCLES-1 without a done_edge: -> IDLE, set timeout_flag, count unchanged.
  - done_edge in that same cycle takes priority: done path, no timeout.
- Undefined: no watchdog logic. WAIT_DONE waits indefinitely; STATUS bit2 reads 0.

Test Plan:
- Reset, read all four addresses -> all readdata 0, irq=0, chrom_start=0.
- Write CHROM=0xA5A5_1234, CTRL=0x5; raise done_in 10 cycles later -> one chrom_start pulse, chrom_data=0xA5A5_1234 held throughout, STATUS=0x2, COUNT=1, irq=1. Write STATUS=0x2 -> irq=0.
- done_in held high before start, then start -> no completion until done_in falls and rises again; COUNT increments by exactly 1.
- Start, then write CHROM=0xFFFF_FFFF while busy, then CTRL=0x2 (abort) -> chrom_data unchanged, STATUS=0x0, COUNT unchanged; a later done_in pulse is ignored.
- COUNT_W=2: four complete runs -> COUNT reads 3 (saturated). Write addr3 -> COUNT reads 0.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=50, done_in held low -> returns to IDLE after 50 WAIT_DONE cycles, STATUS=0x4, irq=1 when irq_en is set.
